// File: rtl/convert_ycc_pkg.sv
// Shared constants for the YCbCr 4:2:2 -> 4:4:4 converter.
// CHROMA_INTERP_EN selects the interpolating build and its latency.
package convert_ycc_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_NEUTRAL_C = 128;

   localparam logic PH_A = 1'b0;
   localparam logic PH_B = 1'b1;

   localparam int LAT_BASE   = 3;
   localparam int LAT_INTERP = 4;

`ifdef CHROMA_INTERP_EN
   localparam int ACT_LAT = LAT_INTERP;
`else
   localparam int ACT_LAT = LAT_BASE;
`endif

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register for hsync/vsync/de, async active-high reset.
// Shared by the video blocks that need control aligned to their data path.
module sync_delay #(
   parameter int DEPTH = 3,
   parameter int W     = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [DEPTH-1:0][W-1:0] sr_q;
   logic [DEPTH-1:0][W-1:0] sr_d;

   always_comb begin
      sr_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
         sr_d[i] = sr_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/convert_422_444.sv
// 4:2:2 -> 4:4:4 YCbCr upsampler: replicates chroma (latency 3), or with
// CHROMA_INTERP_EN defined interpolates it linearly (latency 4).
module convert_422_444
   import convert_ycc_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter bit CB_FIRST  = 1'b1,
   parameter int NEUTRAL_C = DEF_NEUTRAL_C
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] y_in,
   input  logic [DATA_W-1:0] c_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              de_in,
   output logic [DATA_W-1:0] y_out,
   output logic [DATA_W-1:0] cb_out,
   output logic [DATA_W-1:0] cr_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              de_out,
   output logic              pair_start_out
);

   localparam int LAT = ACT_LAT;
   localparam int NS  = LAT - 1;
   localparam int CUR = NS - 1;
   localparam int LA  = NS - 2;
   localparam logic [DATA_W-1:0] NEUT = DATA_W'(NEUTRAL_C);

   logic [NS-1:0][DATA_W-1:0] y_q, y_d;
   logic [NS-1:0][DATA_W-1:0] c_q, c_d;
   logic [NS-1:0]             de_q, de_d;
   logic [NS-1:0]             ph_q, ph_d;

   logic              tgl_q, tgl_d;
   logic [DATA_W-1:0] last_a_q, last_a_d;
   logic [DATA_W-1:0] last_b_q, last_b_d;
   logic              b_seen_q, b_seen_d;

   logic [DATA_W-1:0] y_out_q, y_out_d;
   logic [DATA_W-1:0] cb_out_q, cb_out_d;
   logic [DATA_W-1:0] cr_out_q, cr_out_d;
   logic              ps_q, ps_d;

   logic              de_rise;
   logic              ph_in;
   logic [DATA_W-1:0] cur_y, cur_c, la_c;
   logic              cur_de, cur_a, la_de;
   logic [DATA_W-1:0] b_fb, b_next;
   logic [DATA_W-1:0] a_val, b_val;

`ifdef CHROMA_INTERP_EN
   logic [DATA_W-1:0] a_next, b_prev;

   function automatic logic [DATA_W-1:0] avg(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic [DATA_W:0] s;
      s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
      return s[DATA_W:1];
   endfunction
`endif

   // Slot A is forced on each de rise, then alternates on active pixels.
   always_comb begin
      de_rise = de_in & ~de_q[0];
      ph_in   = de_rise ? PH_A : tgl_q;
      tgl_d   = de_in ? ~ph_in : tgl_q;
      y_d[0]  = y_in;
      c_d[0]  = c_in;
      de_d[0] = de_in;
      ph_d[0] = ph_in;
      for (int i = 1; i < NS; i++) begin
         y_d[i]  = y_q[i-1];
         c_d[i]  = c_q[i-1];
         de_d[i] = de_q[i-1];
         ph_d[i] = ph_q[i-1];
      end
   end

   always_comb begin
      cur_y  = y_q[CUR];
      cur_c  = c_q[CUR];
      cur_de = de_q[CUR];
      cur_a  = (ph_q[CUR] == PH_A);
      la_c   = c_q[LA];
      la_de  = de_q[LA];
      b_fb   = b_seen_q ? last_b_q : NEUT;
      b_next = la_de ? la_c : b_fb;
`ifdef CHROMA_INTERP_EN
      a_next = la_de ? la_c : last_a_q;
      b_prev = b_seen_q ? last_b_q : b_next;
      a_val  = cur_a ? cur_c : avg(last_a_q, a_next);
      b_val  = cur_a ? avg(b_prev, b_next) : cur_c;
`else
      a_val  = cur_a ? cur_c : last_a_q;
      b_val  = cur_a ? b_next : cur_c;
`endif
      last_a_d = last_a_q;
      last_b_d = last_b_q;
      b_seen_d = b_seen_q;
      if (!cur_de) begin
         b_seen_d = 1'b0;
      end else if (cur_a) begin
         last_a_d = cur_c;
      end else begin
         last_b_d = cur_c;
         b_seen_d = 1'b1;
      end
      y_out_d  = '0;
      cb_out_d = '0;
      cr_out_d = '0;
      ps_d     = 1'b0;
      if (cur_de) begin
         y_out_d  = cur_y;
         cb_out_d = CB_FIRST ? a_val : b_val;
         cr_out_d = CB_FIRST ? b_val : a_val;
         ps_d     = cur_a;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q      <= '0;
         c_q      <= '0;
         de_q     <= '0;
         ph_q     <= '0;
         tgl_q    <= PH_A;
         last_a_q <= '0;
         last_b_q <= '0;
         b_seen_q <= 1'b0;
         y_out_q  <= '0;
         cb_out_q <= '0;
         cr_out_q <= '0;
         ps_q     <= 1'b0;
      end else begin
         y_q      <= y_d;
         c_q      <= c_d;
         de_q     <= de_d;
         ph_q     <= ph_d;
         tgl_q    <= tgl_d;
         last_a_q <= last_a_d;
         last_b_q <= last_b_d;
         b_seen_q <= b_seen_d;
         y_out_q  <= y_out_d;
         cb_out_q <= cb_out_d;
         cr_out_q <= cr_out_d;
         ps_q     <= ps_d;
      end
   end

   sync_delay #(
      .DEPTH (LAT),
      .W     (3)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({hsync_in, vsync_in, de_in}),
      .q   ({hsync_out, vsync_out, de_out})
   );

   assign y_out          = y_out_q;
   assign cb_out         = cb_out_q;
   assign cr_out         = cr_out_q;
   assign pair_start_out = ps_q;

endmodule

// File: tb/tb_convert_422_444.sv
// Randomized + directed bench for convert_422_444 (CB_FIRST=1 and 0),
// checked against a line-position reference model.
module tb_convert_422_444;

`ifdef CHROMA_INTERP_EN
   localparam int LAT    = 4;
   localparam bit INTERP = 1'b1;
`else
   localparam int LAT    = 3;
   localparam bit INTERP = 1'b0;
`endif
   localparam int HN = 8192;
   localparam logic [7:0] NEUT = 8'd128;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [7:0] y_in = '0;
   logic [7:0] c_in = '0;
   logic hs_in = 1'b0;
   logic vs_in = 1'b0;
   logic de_in = 1'b0;

   logic [7:0] y1, cb1, cr1, y0, cb0, cr0;
   logic hs1, vs1, de1, ps1, hs0, vs0, de0, ps0;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   bit [7:0] hy [HN];
   bit [7:0] hc [HN];
   bit hde [HN];
   bit hhs [HN];
   bit hvs [HN];

   logic [7:0] ly [16];
   logic [7:0] lc [16];
   logic [27:0] got1 [$];
   logic [27:0] got0 [$];

   always #5 clk = ~clk;

   convert_422_444 #(.CB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .y_in(y_in), .c_in(c_in),
      .hsync_in(hs_in), .vsync_in(vs_in), .de_in(de_in),
      .y_out(y1), .cb_out(cb1), .cr_out(cr1),
      .hsync_out(hs1), .vsync_out(vs1), .de_out(de1),
      .pair_start_out(ps1)
   );

   convert_422_444 #(.CB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .y_in(y_in), .c_in(c_in),
      .hsync_in(hs_in), .vsync_in(vs_in), .de_in(de_in),
      .y_out(y0), .cb_out(cb0), .cr_out(cr0),
      .hsync_out(hs0), .vsync_out(vs0), .de_out(de0),
      .pair_start_out(ps0)
   );

   function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
      return 8'((int'(a) + int'(b) + 1) / 2);
   endfunction

   // Expected output for the pixel that entered on cycle t.
   function automatic logic [27:0] model(input int t, input bit cbf);
      logic [7:0] a, b, bn, bp, an, ax;
      int s, pos;
      if (t < 0) return '0;
      if (!hde[t]) return {24'd0, hhs[t], hvs[t], 2'b00};
      s = t;
      while (s > 0 && hde[s-1]) s--;
      pos = t - s;
      if (pos % 2 == 0) begin
         a = hc[t];
         if (hde[t+1]) bn = hc[t+1];
         else if (pos > 0) bn = hc[t-1];
         else bn = NEUT;
         bp = (pos >= 2) ? hc[t-1] : bn;
         b = INTERP ? avg(bp, bn) : bn;
      end else begin
         b = hc[t];
         an = hc[t-1];
         ax = hde[t+1] ? hc[t+1] : an;
         a = INTERP ? avg(an, ax) : an;
      end
      return {hy[t], cbf ? a : b, cbf ? b : a,
              hhs[t], hvs[t], 1'b1, pos % 2 == 0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input bit r, input logic [7:0] y, input logic [7:0] c,
                       input bit hs, input bit vs, input bit de);
      logic [27:0] o1, o0;
      @(negedge clk);
      o1 = {y1, cb1, cr1, hs1, vs1, de1, ps1};
      o0 = {y0, cb0, cr0, hs0, vs0, de0, ps0};
      chk("out_cbfirst1", 32'(o1), 32'(model(cyc - LAT, 1'b1)));
      chk("out_cbfirst0", 32'(o0), 32'(model(cyc - LAT, 1'b0)));
      if (de1) got1.push_back(o1);
      if (de0) got0.push_back(o0);
      rst = r;
      y_in = y;
      c_in = c;
      hs_in = hs;
      vs_in = vs;
      de_in = de;
      hy[cyc] = r ? 8'd0 : y;
      hc[cyc] = r ? 8'd0 : c;
      hde[cyc] = r ? 1'b0 : de;
      hhs[cyc] = r ? 1'b0 : hs;
      hvs[cyc] = r ? 1'b0 : vs;
      if (r) begin
         for (int j = cyc - LAT + 1; j < cyc; j++) begin
            if (j >= 0) begin
               hy[j] = '0; hc[j] = '0; hde[j] = 0; hhs[j] = 0; hvs[j] = 0;
            end
         end
      end
      cyc++;
   endtask

   task automatic line(input int n, input int gap);
      got1.delete();
      got0.delete();
      for (int i = 0; i < n; i++) step(1'b0, ly[i], lc[i], 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < gap; i++)
         step(1'b0, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
              1'($urandom), 1'($urandom), 1'b0);
   endtask

   task automatic exp_px(input string tag, input bit which, input int i,
                         input logic [7:0] y, input logic [7:0] cb,
                         input logic [7:0] cr, input bit ps);
      logic [27:0] v;
      if (which) chk({tag, "_len"}, 32'(got1.size() > i), 32'd1);
      else chk({tag, "_len"}, 32'(got0.size() > i), 32'd1);
      v = '0;
      if (which && got1.size() > i) v = got1[i];
      if (!which && got0.size() > i) v = got0[i];
      chk(tag, {6'd0, v[27:4], v[1:0]}, {6'd0, y, cb, cr, 1'b1, ps});
   endtask

   initial begin
      #1 rst = 1'b1;
      step(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      chk("reset_state", 32'({y1, cb1, cr1, hs1, vs1, de1, ps1}), 32'd0);
      step(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      ly[0] = 10; ly[1] = 20; ly[2] = 30; ly[3] = 40;
      lc[0] = 50; lc[1] = 60; lc[2] = 70; lc[3] = 80;
`ifdef CHROMA_INTERP_EN
      lc[0] = 100; lc[1] = 200; lc[2] = 51; lc[3] = 0;
      line(4, LAT + 2);
      exp_px("interp_p0", 1, 0, 10, 100, 200, 1);
      exp_px("interp_p1", 1, 1, 20, 76, 200, 0);
      exp_px("interp_p2", 1, 2, 30, 51, 100, 1);
      exp_px("interp_p3", 1, 3, 40, 51, 0, 0);
`else
      line(4, LAT + 2);
      exp_px("line4_p0", 1, 0, 10, 50, 60, 1);
      exp_px("line4_p1", 1, 1, 20, 50, 60, 0);
      exp_px("line4_p2", 1, 2, 30, 70, 80, 1);
      exp_px("line4_p3", 1, 3, 40, 70, 80, 0);
`endif

      ly[0] = 1; ly[1] = 2; ly[2] = 3;
      lc[0] = 50; lc[1] = 60; lc[2] = 70;
      line(3, LAT + 2);
      exp_px("odd3_last", 1, 2, 3, 70, 60, 1);

      ly[0] = 9; lc[0] = 90;
      line(1, LAT + 2);
      exp_px("single_px", 1, 0, 9, 90, 128, 1);

      ly[0] = 5; ly[1] = 6; lc[0] = 60; lc[1] = 50;
      line(2, LAT + 2);
      exp_px("crfirst_p0", 0, 0, 5, 50, 60, 1);
      exp_px("crfirst_p1", 0, 1, 6, 50, 60, 0);

      for (int i = 0; i < 3; i++) step(1'b0, 8'(7 + i), 8'(33 + i), 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      #1 chk("reset_midline", 32'({y1, cb1, cr1, hs1, vs1, de1, ps1}), 32'd0);
      step(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      ly[0] = 44; ly[1] = 55; lc[0] = 11; lc[1] = 22;
      line(2, LAT + 2);
      exp_px("post_rst_p0", 1, 0, 44, 11, 22, 1);
      exp_px("post_rst_p1", 1, 1, 55, 11, 22, 0);

      for (int k = 0; k < 60; k++) begin
         int n;
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            ly[i] = 8'($urandom);
            lc[i] = 8'($urandom);
         end
         line(n, $urandom_range(1, 6));
      end
      for (int i = 0; i < LAT + 2; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
